fft_pease_helpers_twiddle_sequencer: RTL and testbench

- Sequential, multi-stage successor to the per-stage combinational twiddle generator for the pease FFT.
- Holds a loadable sine table of SIZE_FFT entries, where entry m = sin(2*pi*m/N).
- On a stage request it streams that stage's SIZE_FFT/2 twiddle pairs as LANES pairs per beat over a val/rdy interface.
- Sits between the FFT stage controller and a time-multiplexed butterfly array, so one instance serves every stage.

---
 rtl/fft_pease_helpers_twiddle_pkg.sv | 19 +
 rtl/fft_pease_helpers_twiddle_lane_mux.sv | 42 ++++
 rtl/fft_pease_helpers_twiddle_sequencer.sv | 112 +++++++++++
 tb/tb_fft_pease_helpers_twiddle_sequencer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pease_helpers_twiddle_pkg.sv
// Shared types and index arithmetic for the pease FFT twiddle sequencer.
// Holds the sequencer state encoding and the per-stage twiddle index helper.
package fft_pease_helpers_twiddle_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } tw_state_t;

    // Twiddle index at a stage: clear the low (log2n - stage - 1) bits of si.
    function automatic int twiddle_idx(input int si, input int stage, input int log2n);
        int sl;
        sl = log2n - stage - 1;
        if (sl < 0)
            sl = 0;
        return (si >> sl) << sl;
    endfunction

endpackage

// File: rtl/fft_pease_helpers_twiddle_lane_mux.sv
// Purpose: picks the cos/sin sine-table entries for one twiddle lane, optional conjugate.
// Latency: combinational. Backpressure: none, pure function of its inputs.
module fft_pease_helpers_twiddle_lane_mux
    import fft_pease_helpers_twiddle_pkg::*;
#(
    parameter int BIT_WIDTH  = 8,
    parameter int DECIMAL_PT = 4,
    parameter int SIZE_FFT   = 8,
    parameter int LOG2N      = $clog2(SIZE_FFT),
    parameter int STAGE_W    = 2
) (
    input  logic [SIZE_FFT-1:0][BIT_WIDTH-1:0] sine,
    input  logic [STAGE_W-1:0]                 stage,
    input  logic [LOG2N-1:0]                   si,
    input  logic                               neg,
    output logic [BIT_WIDTH-1:0]               re,
    output logic [BIT_WIDTH-1:0]               im
);

    localparam logic [BIT_WIDTH-1:0] ONE = BIT_WIDTH'(1 << DECIMAL_PT);

    logic [LOG2N-1:0]     idx;
    logic [LOG2N-1:0]     re_addr;
    logic [LOG2N-1:0]     im_addr;
    logic [BIT_WIDTH-1:0] im_raw;

    always_comb begin
        idx     = LOG2N'(twiddle_idx(int'(si), int'(stage), LOG2N));
        // idx stays below N/2, so neither offset wraps past the table end.
        re_addr = idx + LOG2N'(SIZE_FFT / 4);
        im_addr = idx + LOG2N'(SIZE_FFT / 2);
        if (stage == '0) begin
            re     = ONE;
            im_raw = '0;
        end else begin
            re     = sine[re_addr];
            im_raw = sine[im_addr];
        end
        im = neg ? (~im_raw + BIT_WIDTH'(1)) : im_raw;
    end

endmodule

// File: rtl/fft_pease_helpers_twiddle_sequencer.sv
// Purpose: streams one FFT stage's twiddle pairs, LANES per beat, from a loadable sine table.
// Latency: first beat valid 1 cycle after request accept; new request on last-beat handshake gives no bubble.
// Backpressure: beat outputs hold while twiddle_send_rdy=0. FFT_PEASE_TWIDDLE_INVERSE_EN adds conjugate output.
module fft_pease_helpers_twiddle_sequencer
    import fft_pease_helpers_twiddle_pkg::*;
#(
    parameter int BIT_WIDTH  = 8,
    parameter int DECIMAL_PT = 4,
    parameter int SIZE_FFT   = 8,
    parameter int LANES      = 2,
    localparam int LOG2N     = $clog2(SIZE_FFT),
    localparam int STAGE_W   = ($clog2(LOG2N) > 1) ? $clog2(LOG2N) : 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              sine_load_en,
    input  logic [LOG2N-1:0]                  sine_load_addr,
    input  logic [BIT_WIDTH-1:0]              sine_load_data,
    output logic                              sine_load_rdy,
    input  logic                              stage_recv_val,
    output logic                              stage_recv_rdy,
    input  logic [STAGE_W-1:0]                stage_recv_msg,
`ifdef FFT_PEASE_TWIDDLE_INVERSE_EN
    input  logic                              stage_recv_inverse,
`endif
    output logic                              twiddle_send_val,
    input  logic                              twiddle_send_rdy,
    output logic [LANES-1:0][BIT_WIDTH-1:0]   twiddle_send_real,
    output logic [LANES-1:0][BIT_WIDTH-1:0]   twiddle_send_imaginary,
    output logic                              twiddle_send_last
);

    localparam int BEATS  = SIZE_FFT / 2 / LANES;
    localparam int BEAT_W = ($clog2(BEATS) > 1) ? $clog2(BEATS) : 1;

    tw_state_t                         state_q;
    logic [BEAT_W-1:0]                 beat_q;
    logic [STAGE_W-1:0]                stage_q;
    logic                              inv_q;
    logic [SIZE_FFT-1:0][BIT_WIDTH-1:0] sine_q;

    logic               accept;
    logic               fire;
    logic               inv_in;
    logic [STAGE_W-1:0] stage_sat;

`ifdef FFT_PEASE_TWIDDLE_INVERSE_EN
    assign inv_in = stage_recv_inverse;
`else
    assign inv_in = 1'b0;
`endif

    assign twiddle_send_val  = (state_q == STREAM);
    assign twiddle_send_last = twiddle_send_val && (beat_q == BEAT_W'(BEATS - 1));
    assign sine_load_rdy     = (state_q == IDLE);
    // Combinational path from twiddle_send_rdy lets the next stage start without a bubble.
    assign stage_recv_rdy    = (state_q == IDLE) || (twiddle_send_last && twiddle_send_rdy);
    assign accept            = stage_recv_val && stage_recv_rdy;
    assign fire              = twiddle_send_val && twiddle_send_rdy;
    assign stage_sat         = (int'(stage_recv_msg) >= LOG2N) ? STAGE_W'(LOG2N - 1) : stage_recv_msg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sine_q <= '0;
        end else if (sine_load_en && sine_load_rdy) begin
            sine_q[sine_load_addr] <= sine_load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            beat_q  <= '0;
            stage_q <= '0;
            inv_q   <= 1'b0;
        end else begin
            if (fire) begin
                if (twiddle_send_last)
                    state_q <= IDLE;
                else
                    beat_q <= beat_q + BEAT_W'(1);
            end
            if (accept) begin
                state_q <= STREAM;
                beat_q  <= '0;
                stage_q <= stage_sat;
                inv_q   <= inv_in;
            end
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [LOG2N-1:0] si;
        assign si = LOG2N'(int'(beat_q) * LANES + l);

        fft_pease_helpers_twiddle_lane_mux #(
            .BIT_WIDTH (BIT_WIDTH),
            .DECIMAL_PT(DECIMAL_PT),
            .SIZE_FFT  (SIZE_FFT),
            .LOG2N     (LOG2N),
            .STAGE_W   (STAGE_W)
        ) u_mux (
            .sine (sine_q),
            .stage(stage_q),
            .si   (si),
            .neg  (inv_q),
            .re   (twiddle_send_real[l]),
            .im   (twiddle_send_imaginary[l])
        );
    end

endmodule

// File: tb/tb_fft_pease_helpers_twiddle_sequencer.sv
// Directed bench for the twiddle sequencer at N=8, Q4.4, LANES=2 with table {00,0B,10,0B,00,F5,F0,F5}.
module tb_fft_pease_helpers_twiddle_sequencer;

    logic            clk = 1'b0;
    logic            reset;
    logic            sine_load_en;
    logic [2:0]      sine_load_addr;
    logic [7:0]      sine_load_data;
    logic            sine_load_rdy;
    logic            stage_recv_val;
    logic            stage_recv_rdy;
    logic [1:0]      stage_recv_msg;
`ifdef FFT_PEASE_TWIDDLE_INVERSE_EN
    logic            stage_recv_inverse;
`endif
    logic            twiddle_send_val;
    logic            twiddle_send_rdy;
    logic [1:0][7:0] twiddle_send_real;
    logic [1:0][7:0] twiddle_send_imaginary;
    logic            twiddle_send_last;

    int errors = 0;
    int checks = 0;
    logic [7:0] sine_tab [8];

    fft_pease_helpers_twiddle_sequencer dut (
        .clk                   (clk),
        .reset                 (reset),
        .sine_load_en          (sine_load_en),
        .sine_load_addr        (sine_load_addr),
        .sine_load_data        (sine_load_data),
        .sine_load_rdy         (sine_load_rdy),
        .stage_recv_val        (stage_recv_val),
        .stage_recv_rdy        (stage_recv_rdy),
        .stage_recv_msg        (stage_recv_msg),
`ifdef FFT_PEASE_TWIDDLE_INVERSE_EN
        .stage_recv_inverse    (stage_recv_inverse),
`endif
        .twiddle_send_val      (twiddle_send_val),
        .twiddle_send_rdy      (twiddle_send_rdy),
        .twiddle_send_real     (twiddle_send_real),
        .twiddle_send_imaginary(twiddle_send_imaginary),
        .twiddle_send_last     (twiddle_send_last)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input logic last,
                            input logic [7:0] r0, input logic [7:0] r1,
                            input logic [7:0] i0, input logic [7:0] i1);
        chk({tag, ".val"}, 32'(twiddle_send_val), 32'd1);
        chk({tag, ".last"}, 32'(twiddle_send_last), 32'(last));
        chk({tag, ".re"}, {16'h0, twiddle_send_real[1], twiddle_send_real[0]}, {16'h0, r1, r0});
        chk({tag, ".im"}, {16'h0, twiddle_send_imaginary[1], twiddle_send_imaginary[0]}, {16'h0, i1, i0});
    endtask

    task automatic load_table();
        for (int i = 0; i < 8; i++) begin
            sine_load_en   = 1'b1;
            sine_load_addr = 3'(i);
            sine_load_data = sine_tab[i];
            step();
        end
        sine_load_en = 1'b0;
    endtask

    initial begin
        sine_tab = '{8'h00, 8'h0B, 8'h10, 8'h0B, 8'h00, 8'hF5, 8'hF0, 8'hF5};
        reset = 1'b0;
        sine_load_en = 1'b0;
        sine_load_addr = '0;
        sine_load_data = '0;
        stage_recv_val = 1'b0;
        stage_recv_msg = '0;
        twiddle_send_rdy = 1'b1;
`ifdef FFT_PEASE_TWIDDLE_INVERSE_EN
        stage_recv_inverse = 1'b0;
`endif
        step();
        step();
        chk("rst.val", 32'(twiddle_send_val), 32'd0);
        chk("rst.last", 32'(twiddle_send_last), 32'd0);
        chk("rst.recv_rdy", 32'(stage_recv_rdy), 32'd1);
        chk("rst.load_rdy", 32'(sine_load_rdy), 32'd1);
        reset = 1'b1;
        load_table();

        // Stage 0; a load attempted mid-stream must be dropped.
        stage_recv_val = 1'b1; stage_recv_msg = 2'd0;
        step();
        stage_recv_val = 1'b0;
        chk("s0.load_rdy", 32'(sine_load_rdy), 32'd0);
        chk_beat("s0.b0", 1'b0, 8'h10, 8'h10, 8'h00, 8'h00);
        sine_load_en = 1'b1; sine_load_addr = 3'd4; sine_load_data = 8'h7F;
        step();
        sine_load_en = 1'b0;
        chk_beat("s0.b1", 1'b1, 8'h10, 8'h10, 8'h00, 8'h00);
        step();
        chk("s0.idle", 32'(twiddle_send_val), 32'd0);

        // Stage 1
        stage_recv_val = 1'b1; stage_recv_msg = 2'd1;
        step();
        stage_recv_val = 1'b0;
        chk_beat("s1.b0", 1'b0, 8'h10, 8'h10, 8'h00, 8'h00);
        step();
        chk_beat("s1.b1", 1'b1, 8'h00, 8'h00, 8'hF0, 8'hF0);
        step();
        chk("s1.idle", 32'(twiddle_send_val), 32'd0);

        // Stage 2 with consumer stalled for 3 cycles
        twiddle_send_rdy = 1'b0;
        stage_recv_val = 1'b1; stage_recv_msg = 2'd2;
        step();
        stage_recv_val = 1'b0;
        chk_beat("s2.stall0", 1'b0, 8'h10, 8'h0B, 8'h00, 8'hF5);
        step();
        chk_beat("s2.stall1", 1'b0, 8'h10, 8'h0B, 8'h00, 8'hF5);
        step();
        chk_beat("s2.stall2", 1'b0, 8'h10, 8'h0B, 8'h00, 8'hF5);
        twiddle_send_rdy = 1'b1;
        step();
        chk_beat("s2.b1", 1'b1, 8'h00, 8'hF5, 8'hF0, 8'hF5);
        step();
        chk("s2.idle", 32'(twiddle_send_val), 32'd0);

        // Back-to-back stage 1 then stage 2
        stage_recv_val = 1'b1; stage_recv_msg = 2'd1;
        step();
        stage_recv_msg = 2'd2;
        chk_beat("bb.s1b0", 1'b0, 8'h10, 8'h10, 8'h00, 8'h00);
        chk("bb.rdy0", 32'(stage_recv_rdy), 32'd0);
        step();
        chk_beat("bb.s1b1", 1'b1, 8'h00, 8'h00, 8'hF0, 8'hF0);
        chk("bb.rdy_last", 32'(stage_recv_rdy), 32'd1);
        step();
        stage_recv_val = 1'b0;
        chk_beat("bb.s2b0", 1'b0, 8'h10, 8'h0B, 8'h00, 8'hF5);
        step();
        chk_beat("bb.s2b1", 1'b1, 8'h00, 8'hF5, 8'hF0, 8'hF5);
        step();
        chk("bb.idle", 32'(twiddle_send_val), 32'd0);

        // Out-of-range stage saturates to the last stage
        stage_recv_val = 1'b1; stage_recv_msg = 2'd3;
        step();
        stage_recv_val = 1'b0;
        chk_beat("sat.b0", 1'b0, 8'h10, 8'h0B, 8'h00, 8'hF5);
        step();
        chk_beat("sat.b1", 1'b1, 8'h00, 8'hF5, 8'hF0, 8'hF5);
        step();

        // Reset during beat 0 of stage 2
        stage_recv_val = 1'b1; stage_recv_msg = 2'd2;
        step();
        stage_recv_val = 1'b0;
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("mrst.val", 32'(twiddle_send_val), 32'd0);
        chk("mrst.recv_rdy", 32'(stage_recv_rdy), 32'd1);
        step();
        chk("mrst.quiet", 32'(twiddle_send_val), 32'd0);
        stage_recv_val = 1'b1; stage_recv_msg = 2'd1;
        step();
        stage_recv_val = 1'b0;
        chk_beat("mrst.b0", 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
        step();
        chk_beat("mrst.b1", 1'b1, 8'h00, 8'h00, 8'h00, 8'h00);
        step();

        // Write and request in the same cycle: stream sees the new entry
        sine_load_en = 1'b1; sine_load_addr = 3'd2; sine_load_data = 8'h10;
        stage_recv_val = 1'b1; stage_recv_msg = 2'd1;
        step();
        sine_load_en = 1'b0;
        stage_recv_val = 1'b0;
        chk_beat("sim.b0", 1'b0, 8'h10, 8'h10, 8'h00, 8'h00);
        step();
        step();
        load_table();

`ifdef FFT_PEASE_TWIDDLE_INVERSE_EN
        stage_recv_val = 1'b1; stage_recv_msg = 2'd2; stage_recv_inverse = 1'b1;
        step();
        stage_recv_val = 1'b0; stage_recv_inverse = 1'b0;
        chk_beat("inv2.b0", 1'b0, 8'h10, 8'h0B, 8'h00, 8'h0B);
        step();
        chk_beat("inv2.b1", 1'b1, 8'h00, 8'hF5, 8'h10, 8'h0B);
        step();
        stage_recv_val = 1'b1; stage_recv_msg = 2'd3; stage_recv_inverse = 1'b1;
        step();
        stage_recv_val = 1'b0; stage_recv_inverse = 1'b0;
        chk_beat("inv3.b0", 1'b0, 8'h10, 8'h0B, 8'h00, 8'h0B);
        step();
        chk_beat("inv3.b1", 1'b1, 8'h00, 8'hF5, 8'h10, 8'h0B);
        step();
        stage_recv_val = 1'b1; stage_recv_msg = 2'd0; stage_recv_inverse = 1'b1;
        step();
        stage_recv_val = 1'b0; stage_recv_inverse = 1'b0;
        chk_beat("inv0.b0", 1'b0, 8'h10, 8'h10, 8'h00, 8'h00);
        step();
        step();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
